accum_ctrl_nbit: RTL and testbench

//   Sequential accumulator controller. It sits directly upstream of adder_nbit and drives it:
//   the running total goes to adder a, each accepted sample goes to adder b, and carry_in is

---
 rtl/accum_ctrl_nbit.sv | 107 ++++++++++
 tb/tb_accum_ctrl_nbit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/accum_ctrl_nbit.sv
// Sequential accumulator controller driving an adder_nbit; sums num_samples samples into acc_out.
// Optional build macro ACCUM_SATURATE_EN clamps the total to all ones on carry-out instead of wrapping.

module adder_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};

endmodule

module accum_ctrl_nbit #(
  parameter int BIT_WIDTH = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_samples,
  input  logic                 data_valid,
  input  logic [BIT_WIDTH-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] acc_out,
  output logic                 overflow,
  output logic [1:0]           state_dbg
);

  // Handshake: a sample is consumed on every rising edge in ACCUM where data_valid=1;
  // there is no ready, the upstream must only assert data_valid while busy and not done.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] count;
  logic [BIT_WIDTH-1:0] add_sum;
  logic                 add_carry;
  logic [BIT_WIDTH-1:0] next_acc;

  adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_adder (
    .a         (acc_out),
    .b         (data_in),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_carry)
  );

`ifdef ACCUM_SATURATE_EN
  // Any carry pins the total at all ones; adding to all ones always carries or adds 0, so it sticks.
  always_comb begin
    next_acc = add_sum;
    if (add_carry) next_acc = '1;
  end
`else
  always_comb begin
    next_acc = add_sum;
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      count    <= '0;
      acc_out  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_out  <= '0;
            overflow <= 1'b0;
            if (num_samples != '0) begin
              count <= num_samples;
              state <= ACCUM;
            end else begin
              state <= DONE;
            end
          end
        end
        ACCUM: begin
          if (data_valid) begin
            acc_out  <= next_acc;
            overflow <= overflow | add_carry;
            count    <= count - CNT_ONE;
            if (count == CNT_ONE) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == ACCUM) || (state == DONE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_accum_ctrl_nbit.sv
// Directed bench for accum_ctrl_nbit (BIT_WIDTH=4, CNT_WIDTH=4); expectations hand-computed.

module tb_accum_ctrl_nbit;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic [3:0] num_samples;
  logic       data_valid;
  logic [3:0] data_in;
  logic       busy;
  logic       done;
  logic [3:0] acc_out;
  logic       overflow;
  logic [1:0] state_dbg;

  int n_cmp;
  int n_err;

  accum_ctrl_nbit #(.BIT_WIDTH(4), .CNT_WIDTH(4)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .num_samples (num_samples),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .acc_out     (acc_out),
    .overflow    (overflow),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic s, input logic [3:0] n, input logic v, input logic [3:0] d);
    start       = s;
    num_samples = n;
    data_valid  = v;
    data_in     = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_rst = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 4'd0);
    #12;
    check("rst_acc", {4'd0, acc_out}, 8'd0);
    check("rst_ovf", {7'd0, overflow}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_state", {6'd0, state_dbg}, 8'd0);
    n_rst = 1'b1;
    step();

    // data_valid in IDLE is ignored
    drive(1'b0, 4'd0, 1'b1, 4'd9);
    step();
    check("idle_dv_acc", {4'd0, acc_out}, 8'd0);
    check("idle_dv_busy", {7'd0, busy}, 8'd0);

    // async reset mid-run with acc_out=7
    drive(1'b1, 4'd5, 1'b0, 4'd0);
    step();
    check("t1_busy", {7'd0, busy}, 8'd1);
    drive(1'b0, 4'd0, 1'b1, 4'd3);
    step();
    drive(1'b0, 4'd0, 1'b1, 4'd4);
    step();
    check("t1_acc7", {4'd0, acc_out}, 8'd7);
    drive(1'b0, 4'd0, 1'b0, 4'd0);
    n_rst = 1'b0;
    #1;
    check("t1_rst_acc", {4'd0, acc_out}, 8'd0);
    check("t1_rst_ovf", {7'd0, overflow}, 8'd0);
    check("t1_rst_busy", {7'd0, busy}, 8'd0);
    check("t1_rst_done", {7'd0, done}, 8'd0);
    n_rst = 1'b1;
    step();
    check("t1_idle", {6'd0, state_dbg}, 8'd0);
    check("t1_idle_done", {7'd0, done}, 8'd0);

    // 3 samples back-to-back: 2+3+4 = 9
    drive(1'b1, 4'd3, 1'b0, 4'd0);
    step();
    drive(1'b0, 4'd0, 1'b1, 4'd2);
    step();
    check("t2_acc_a", {4'd0, acc_out}, 8'd2);
    drive(1'b0, 4'd0, 1'b1, 4'd3);
    step();
    check("t2_acc_b", {4'd0, acc_out}, 8'd5);
    check("t2_done_early", {7'd0, done}, 8'd0);
    drive(1'b0, 4'd0, 1'b1, 4'd4);
    step();
    check("t2_acc", {4'd0, acc_out}, 8'd9);
    check("t2_ovf", {7'd0, overflow}, 8'd0);
    check("t2_done", {7'd0, done}, 8'd1);
    check("t2_busy", {7'd0, busy}, 8'd1);
    // data_valid during DONE is ignored
    drive(1'b0, 4'd0, 1'b1, 4'd4);
    step();
    check("t2_done_off", {7'd0, done}, 8'd0);
    check("t2_busy_off", {7'd0, busy}, 8'd0);
    check("t2_hold", {4'd0, acc_out}, 8'd9);
    drive(1'b0, 4'd0, 1'b0, 4'd0);
    step();
    check("t2_hold2", {4'd0, acc_out}, 8'd9);

    // 15 + 2 overflows
    drive(1'b1, 4'd2, 1'b0, 4'd0);
    step();
    check("t3_clear", {4'd0, acc_out}, 8'd0);
    drive(1'b0, 4'd0, 1'b1, 4'd15);
    step();
    check("t3_acc_a", {4'd0, acc_out}, 8'd15);
    check("t3_ovf_a", {7'd0, overflow}, 8'd0);
    drive(1'b0, 4'd0, 1'b1, 4'd2);
    step();
`ifdef ACCUM_SATURATE_EN
    check("t3_acc", {4'd0, acc_out}, 8'd15);
`else
    check("t3_acc", {4'd0, acc_out}, 8'd1);
`endif
    check("t3_ovf", {7'd0, overflow}, 8'd1);
    check("t3_done", {7'd0, done}, 8'd1);
    drive(1'b0, 4'd0, 1'b0, 4'd0);
    step();
    check("t3_ovf_hold", {7'd0, overflow}, 8'd1);

    // num_samples = 0: done next cycle, totals cleared
    drive(1'b1, 4'd0, 1'b0, 4'd0);
    step();
    check("t5_done", {7'd0, done}, 8'd1);
    check("t5_acc", {4'd0, acc_out}, 8'd0);
    check("t5_ovf", {7'd0, overflow}, 8'd0);
    drive(1'b0, 4'd0, 1'b0, 4'd0);
    step();
    check("t5_done_off", {7'd0, done}, 8'd0);

    // 1,1,1 with two idle cycles between samples
    drive(1'b1, 4'd3, 1'b0, 4'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd0, 1'b1, 4'd1);
      step();
      if (i < 2) begin
        check("t4_no_done", {7'd0, done}, 8'd0);
        drive(1'b0, 4'd0, 1'b0, 4'd7);
        step();
        step();
        check("t4_gap_busy", {7'd0, busy}, 8'd1);
        check("t4_gap_done", {7'd0, done}, 8'd0);
      end
    end
    check("t4_acc", {4'd0, acc_out}, 8'd3);
    check("t4_done", {7'd0, done}, 8'd1);
    drive(1'b0, 4'd0, 1'b0, 4'd0);
    step();

    // start during ACCUM is ignored: 5+6+2 = 13 over 3 samples
    drive(1'b1, 4'd3, 1'b0, 4'd0);
    step();
    drive(1'b0, 4'd0, 1'b1, 4'd5);
    step();
    drive(1'b1, 4'd1, 1'b1, 4'd6);
    step();
    check("t6_acc_b", {4'd0, acc_out}, 8'd11);
    check("t6_no_done", {7'd0, done}, 8'd0);
    drive(1'b1, 4'd1, 1'b0, 4'd0);
    step();
    check("t6_still_busy", {7'd0, busy}, 8'd1);
    check("t6_acc_hold", {4'd0, acc_out}, 8'd11);
    drive(1'b0, 4'd0, 1'b1, 4'd2);
    step();
    check("t6_acc", {4'd0, acc_out}, 8'd13);
    check("t6_done", {7'd0, done}, 8'd1);
    drive(1'b0, 4'd0, 1'b0, 4'd0);
    step();
    check("t6_idle", {6'd0, state_dbg}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
